md_unit: RTL and testbench

Iterative RV32M multiply/divide unit sitting beside the single-cycle ALU in the execute stage. The decode/execute controller launches one M-extension operation with a start pulse; the unit holds the pipeline via `busy` and returns a 32-bit result with a one-cycle `done` strobe. It uses a radix-2 shift-add multiplier and a restoring divider sequenced by a small FSM and a 5-bit iteration counter, so only one adder is needed.

---
 rtl/md_unit.sv | 185 ++++++++++++++++++
 tb/tb_md_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiplier and restoring
// divider sharing one 64-bit accumulator, sequenced IDLE -> CALC -> FIX -> DONE.
module md_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

    state_e      state_q;
    logic [63:0] acc_q;
    logic [31:0] den_q;
    logic [4:0]  cnt_q;
    logic [2:0]  op_q;
    logic        neg_q;
    logic        a_neg_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] result_q;

    logic        a_signed_s;
    logic        b_signed_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic [31:0] mag_a_s;
    logic [31:0] mag_b_s;
    logic        special_s;
    logic [31:0] special_res_s;
    logic [32:0] mul_sum_s;
    logic [32:0] div_rem_s;
    logic [32:0] div_diff_s;
    logic [63:0] iter_acc_d;
    logic [63:0] prod_fix_s;
    logic [31:0] fix_res_d;

    // Launch decode: operand magnitudes, signs and the divide special cases.
    always_comb begin
        a_signed_s    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                        (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed_s    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg_s       = a_signed_s && op_a[31];
        b_neg_s       = b_signed_s && op_b[31];
        mag_a_s       = a_neg_s ? neg32(op_a) : op_a;
        mag_b_s       = b_neg_s ? neg32(op_b) : op_b;
        special_s     = 1'b0;
        special_res_s = 32'd0;
        if (funct3[2] && (op_b == 32'd0)) begin
            special_s     = 1'b1;
            special_res_s = funct3[1] ? op_a : 32'hFFFF_FFFF;
        end else if (funct3[2] && !funct3[0] && (op_a == 32'h8000_0000) &&
                     (op_b == 32'hFFFF_FFFF)) begin
            special_s     = 1'b1;
            special_res_s = funct3[1] ? 32'd0 : 32'h8000_0000;
        end else begin
            special_s     = 1'b0;
            special_res_s = 32'd0;
        end
    end

    // One iteration step; the divide uses acc bit 63 so the shifted remainder keeps 33 bits.
    always_comb begin
        mul_sum_s  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, den_q} : 33'd0);
        div_rem_s  = acc_q[63:31];
        div_diff_s = div_rem_s - {1'b0, den_q};
        if (op_q[2]) begin
            if (!div_diff_s[32]) begin
                iter_acc_d = {div_diff_s[31:0], acc_q[30:0], 1'b1};
            end else begin
                iter_acc_d = {div_rem_s[31:0], acc_q[30:0], 1'b0};
            end
        end else begin
            iter_acc_d = {mul_sum_s, acc_q[31:1]};
        end
    end

    // Sign fix-up and output selection.
    always_comb begin
        prod_fix_s = neg_q ? neg64(acc_q) : acc_q;
        case (op_q)
            3'b000:  fix_res_d = prod_fix_s[31:0];
            3'b001,
            3'b010,
            3'b011:  fix_res_d = prod_fix_s[63:32];
            3'b100,
            3'b101:  fix_res_d = neg_q ? neg32(acc_q[31:0]) : acc_q[31:0];
            3'b110,
            3'b111:  fix_res_d = a_neg_q ? neg32(acc_q[63:32]) : acc_q[63:32];
            default: fix_res_d = 32'd0;
        endcase
    end

    // Sequencer with registered busy/done/result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= 64'd0;
            den_q    <= 32'd0;
            cnt_q    <= 5'd0;
            op_q     <= 3'd0;
            neg_q    <= 1'b0;
            a_neg_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 32'd0;
        end else if (kill) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= funct3;
                        neg_q   <= a_neg_s ^ b_neg_s;
                        a_neg_q <= a_neg_s;
                        cnt_q   <= 5'd0;
                        acc_q   <= {32'd0, (funct3[2] ? mag_a_s : mag_b_s)};
                        den_q   <= funct3[2] ? mag_b_s : mag_a_s;
                        busy_q  <= 1'b1;
                        if (special_s) begin
                            result_q <= special_res_s;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            state_q <= S_CALC;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_CALC: begin
                    acc_q <= iter_acc_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= S_FIX;
                    end else begin
                        state_q <= S_CALC;
                    end
                end
                S_FIX: begin
                    result_q <= fix_res_d;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: arithmetic vectors, latency,
// special-case divides, kill, start/kill collision, held start and mid-op reset.
module tb_md_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        kill;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks;
    int errors;

    md_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .kill   (kill),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation; lat = edges after the accepting edge until done is seen.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        funct3 = f;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        funct3 = ~f;
        op_a   = ~a;
        op_b   = ~b;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = result;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        kill = 1'b0;
        funct3 = 3'b000;
        op_a = 32'd0;
        op_b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            $display("FAIL reset: busy=%b done=%b result=%h, required 0 0 00000000", busy, done, result);
            errors++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_arith();
        logic [2:0]  f [12];
        logic [31:0] a [12];
        logic [31:0] b [12];
        logic [31:0] e [12];
        logic [31:0] res;
        int lat;
        f[0]  = 3'b000; a[0]  = 32'h0000_0007; b[0]  = 32'hFFFF_FFFD; e[0]  = 32'hFFFF_FFEB;
        f[1]  = 3'b001; a[1]  = 32'h0000_0007; b[1]  = 32'hFFFF_FFFD; e[1]  = 32'hFFFF_FFFF;
        f[2]  = 3'b011; a[2]  = 32'h0000_0007; b[2]  = 32'hFFFF_FFFD; e[2]  = 32'h0000_0006;
        f[3]  = 3'b010; a[3]  = 32'hFFFF_FFFF; b[3]  = 32'hFFFF_FFFF; e[3]  = 32'hFFFF_FFFF;
        f[4]  = 3'b001; a[4]  = 32'h8000_0000; b[4]  = 32'h8000_0000; e[4]  = 32'h4000_0000;
        f[5]  = 3'b100; a[5]  = 32'hFFFF_FFF9; b[5]  = 32'h0000_0002; e[5]  = 32'hFFFF_FFFD;
        f[6]  = 3'b110; a[6]  = 32'hFFFF_FFF9; b[6]  = 32'h0000_0002; e[6]  = 32'hFFFF_FFFF;
        f[7]  = 3'b101; a[7]  = 32'hFFFF_FFFF; b[7]  = 32'h0000_0010; e[7]  = 32'h0FFF_FFFF;
        f[8]  = 3'b111; a[8]  = 32'hFFFF_FFFF; b[8]  = 32'h0000_0010; e[8]  = 32'h0000_000F;
        f[9]  = 3'b101; a[9]  = 32'hFFFF_FFFF; b[9]  = 32'h8000_0001; e[9]  = 32'h0000_0001;
        f[10] = 3'b111; a[10] = 32'hFFFF_FFFF; b[10] = 32'h8000_0001; e[10] = 32'h7FFF_FFFE;
        f[11] = 3'b110; a[11] = 32'h0000_0007; b[11] = 32'hFFFF_FFFE; e[11] = 32'h0000_0001;
        for (int i = 0; i < 12; i++) begin
            do_op(f[i], a[i], b[i], res, lat);
            checks++;
            if (res !== e[i]) begin
                $display("FAIL arith[%0d] f=%b: result=%h, required %h", i, f[i], res, e[i]);
                errors++;
            end
            checks++;
            if (lat !== 33) begin
                $display("FAIL arith_latency[%0d]: edges=%0d, required 33", i, lat);
                errors++;
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL done_width: done=%b busy=%b, required 0 0", done, busy);
            errors++;
        end
    endtask

    task automatic test_special();
        logic [2:0]  f [4];
        logic [31:0] a [4];
        logic [31:0] b [4];
        logic [31:0] e [4];
        logic [31:0] res;
        int lat;
        f[0] = 3'b101; a[0] = 32'd5;          b[0] = 32'd0;          e[0] = 32'hFFFF_FFFF;
        f[1] = 3'b110; a[1] = 32'd5;          b[1] = 32'd0;          e[1] = 32'd5;
        f[2] = 3'b100; a[2] = 32'h8000_0000;  b[2] = 32'hFFFF_FFFF;  e[2] = 32'h8000_0000;
        f[3] = 3'b110; a[3] = 32'h8000_0000;  b[3] = 32'hFFFF_FFFF;  e[3] = 32'd0;
        for (int i = 0; i < 4; i++) begin
            do_op(f[i], a[i], b[i], res, lat);
            checks++;
            if (res !== e[i]) begin
                $display("FAIL special[%0d] f=%b: result=%h, required %h", i, f[i], res, e[i]);
                errors++;
            end
            checks++;
            if (lat !== 0) begin
                $display("FAIL special_latency[%0d]: edges=%0d, required 0", i, lat);
                errors++;
            end
        end
    endtask

    task automatic test_kill();
        logic [31:0] prior;
        logic [31:0] res;
        int lat;
        int seen;
        do_op(3'b000, 32'd3, 32'd5, res, lat);
        prior = res;
        checks++;
        if (prior !== 32'd15) begin
            $display("FAIL kill_setup: result=%h, required 0000000f", prior);
            errors++;
        end
        @(negedge clk);
        funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL kill_busy: busy=%b, required 0", busy);
            errors++;
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (seen !== 0 || result !== prior) begin
            $display("FAIL kill_no_done: dones=%0d result=%h, required 0 %h", seen, result, prior);
            errors++;
        end
        @(negedge clk);
        start = 1'b1; kill = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL start_kill_busy: busy=%b, required 0", busy);
            errors++;
        end
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL start_kill_idle: busy=%b done=%b, required 0 0", busy, done);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int dones;
        @(negedge clk);
        funct3 = 3'b000; op_a = 32'd6; op_b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        dones = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (done) dones++;
        checks++;
        if (lat !== 33 || result !== 32'd42) begin
            $display("FAIL held_start_first: edges=%0d result=%h, required 33 0000002a", lat, result);
            errors++;
        end
        @(posedge clk);
        #1;
        if (done) dones++;
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL held_start_gap: busy=%b, required 0", busy);
            errors++;
        end
        @(posedge clk);
        #1;
        if (done) dones++;
        checks++;
        if (busy !== 1'b1) begin
            $display("FAIL held_start_relaunch: busy=%b, required 1", busy);
            errors++;
        end
        checks++;
        if (dones !== 1) begin
            $display("FAIL held_start_count: completions=%0d, required 1", dones);
            errors++;
        end
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (!done || result !== 32'd42) begin
            $display("FAIL relaunch_result: done=%b result=%h, required 1 0000002a", done, result);
            errors++;
        end
    endtask

    task automatic test_rst_midop();
        @(negedge clk);
        funct3 = 3'b011; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; start = 1'b1; kill = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            $display("FAIL rst_midop: busy=%b done=%b result=%h, required 0 0 00000000", busy, done, result);
            errors++;
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0; kill = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_arith();
        test_special();
        test_kill();
        test_back_to_back();
        test_rst_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
